// File: rtl/emmc_traffic_gen_pkg.sv
// emmc_tg_p: shared types and LFSR tap table for the eMMC traffic generator.
package emmc_tg_p;

   typedef enum logic [1:0] {PM_ALT, PM_INCR, PM_LFSR, PM_CONST} pattern_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_START, ST_WR_DATA, ST_GUARD, ST_RD_START, ST_RD_DATA, ST_DONE
   } tg_state_e;

   // Maximal-length Fibonacci tap masks; bit n-1 is the x^n term.
   function automatic logic [63:0] lfsr_taps(input int width);
      case (width)
         8:       return 64'hB8;
         16:      return 64'hB400;
         32:      return 64'h8020_0003;
         64:      return 64'hD800_0000_0000_0000;
         default: return 64'h3 << (width - 2);
      endcase
   endfunction

endpackage

// File: rtl/emmc_traffic_gen_pattern_gen.sv
// emmc_pattern_gen: seeded word generator; the write source and read checker use
// identical instances, so their sequences match by construction.
module emmc_pattern_gen
   import emmc_tg_p::*;
#(
   parameter int          DATA_W = 16,
   parameter logic [63:0] SEED   = 64'h5555
) (
   input  logic              clk_core,
   input  logic              rst_manual,
   input  logic              load_i,
   input  logic              adv_i,
   input  pattern_mode_e     mode_i,
   output logic [DATA_W-1:0] word_o
);

   localparam logic [DATA_W-1:0] SEED_W = SEED[DATA_W-1:0];
   localparam logic [63:0]       TAPS64 = lfsr_taps(DATA_W);
   localparam logic [DATA_W-1:0] TAPS   = TAPS64[DATA_W-1:0];

   logic [DATA_W-1:0] word_q, word_d, next_w;

   always_comb begin
      next_w = mode_i == PM_ALT  ? ~word_q :
               mode_i == PM_INCR ? word_q + DATA_W'(1) :
               mode_i == PM_LFSR ? {word_q[DATA_W-2:0], ^(word_q & TAPS)} : word_q;
      // An all-zero LFSR state would lock up, so the seed is forced to 1.
      word_d = load_i ? ((mode_i == PM_LFSR && SEED_W == '0) ? DATA_W'(1) : SEED_W) :
               adv_i  ? next_w : word_q;
   end

   always_ff @(posedge clk_core or posedge rst_manual)
      if (rst_manual) word_q <= SEED_W;
      else            word_q <= word_d;

   assign word_o = word_q;

endmodule

// File: rtl/emmc_traffic_gen.sv
// emmc_traffic_gen: writes blk_cnt blocks of a pattern to emmc_sm, reads them back
// and checks every word, reporting pass/fail, error count, first error and timeout.
module emmc_traffic_gen
   import emmc_tg_p::*;
#(
   parameter int          DATA_W      = 16,
   parameter int          BLK_BYTES   = 512,
   parameter int          BLK_W       = 16,
   parameter logic [63:0] SEED        = 64'h5555,
   parameter int          GUARD_CYC   = 1024,
   parameter int          TIMEOUT_CYC = 2**20,
   parameter int          ERR_W       = 16,
   localparam int         WPB         = BLK_BYTES * 8 / DATA_W,
   localparam int         WC_W        = BLK_W + $clog2(WPB)
) (
   input  logic              clk_core,
   input  logic              rst_manual,
   input  logic              run_i,
   input  logic              abort_i,
   input  logic [1:0]        mode_i,
   input  logic [BLK_W-1:0]  blk_cnt_i,
   output logic              sm_we_o,
   output logic              sm_start_o,
   output logic [BLK_W-1:0]  sm_blk_cnt_o,
   output logic [DATA_W-1:0] sm_dat_o,
   input  logic              sm_ready_i,
   input  logic [DATA_W-1:0] sm_dat_i,
   input  logic              sm_dvalid_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              timeout_o,
   output logic [ERR_W-1:0]  err_cnt_o,
   output logic [WC_W-1:0]   first_err_o
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam int GD_W = $clog2(GUARD_CYC + 1);

   tg_state_e         state_q, state_d;
   pattern_mode_e     mode_q, mode_d, gen_mode;
   logic [BLK_W-1:0]  blk_q, blk_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d, first_err_q, first_err_d, total;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [GD_W-1:0]   gd_q, gd_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              tout_q, tout_d;
   logic              load, start, wr_adv, rd_adv, last, xfer, expire, mism;
   logic [DATA_W-1:0] exp_w;

   always_comb begin
      total    = WC_W'(blk_q) * WC_W'(WPB);
      load     = (state_q == ST_IDLE || state_q == ST_DONE) && run_i && !abort_i;
      start    = state_q == ST_WR_START || state_q == ST_RD_START;
      wr_adv   = state_q == ST_WR_DATA && sm_ready_i;
      rd_adv   = state_q == ST_RD_DATA && sm_dvalid_i;
      xfer     = state_q == ST_WR_DATA || state_q == ST_RD_DATA;
      last     = wcnt_q == total - WC_W'(1);
      // A word accepted in the expiry cycle counts as progress, so the accept wins.
      expire   = xfer && !wr_adv && !rd_adv && wd_q == WD_W'(TIMEOUT_CYC - 1);
      mism     = rd_adv && sm_dat_i != exp_w;
      gen_mode = load ? pattern_mode_e'(mode_i) : mode_q;
      mode_d   = gen_mode;
      blk_d    = load ? blk_cnt_i : blk_q;
      wcnt_d   = start ? '0 : (wr_adv || rd_adv) ? wcnt_q + WC_W'(1) : wcnt_q;
      wd_d     = (start || wr_adv || rd_adv) ? '0 : xfer ? wd_q + WD_W'(1) : wd_q;
      gd_d     = state_q == ST_GUARD ? gd_q + GD_W'(1) : '0;
      err_d    = load ? '0 : (mism && !(&err_q)) ? err_q + ERR_W'(1) : err_q;
      first_err_d = load ? '0 : (mism && err_q == '0) ? wcnt_q : first_err_q;
      tout_d   = load ? 1'b0 : (expire && !abort_i) ? 1'b1 : tout_q;
      state_d  = state_q;
      if (abort_i) state_d = ST_IDLE;
      else
         case (state_q)
            ST_IDLE, ST_DONE: if (run_i) state_d = blk_cnt_i == '0 ? ST_DONE : ST_WR_START;
            ST_WR_START:      state_d = ST_WR_DATA;
            ST_WR_DATA:       state_d = (wr_adv && last) ? ST_GUARD : expire ? ST_DONE : state_q;
            ST_GUARD:         state_d = gd_q == GD_W'(GUARD_CYC - 1) ? ST_RD_START : state_q;
            ST_RD_START:      state_d = ST_RD_DATA;
            ST_RD_DATA:       state_d = ((rd_adv && last) || expire) ? ST_DONE : state_q;
            default:          state_d = ST_IDLE;
         endcase
   end

   always_ff @(posedge clk_core or posedge rst_manual)
      if (rst_manual) begin
         state_q     <= ST_IDLE;
         mode_q      <= PM_ALT;
         blk_q       <= '0;
         wcnt_q      <= '0;
         wd_q        <= '0;
         gd_q        <= '0;
         err_q       <= '0;
         first_err_q <= '0;
         tout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         blk_q       <= blk_d;
         wcnt_q      <= wcnt_d;
         wd_q        <= wd_d;
         gd_q        <= gd_d;
         err_q       <= err_d;
         first_err_q <= first_err_d;
         tout_q      <= tout_d;
      end

   emmc_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
      .clk_core(clk_core), .rst_manual(rst_manual), .load_i(load), .adv_i(wr_adv),
      .mode_i(gen_mode), .word_o(sm_dat_o)
   );

   emmc_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_rd_gen (
      .clk_core(clk_core), .rst_manual(rst_manual), .load_i(load), .adv_i(rd_adv),
      .mode_i(gen_mode), .word_o(exp_w)
   );

   assign sm_start_o   = start && !abort_i;
   assign sm_we_o      = (state_q == ST_WR_START || state_q == ST_WR_DATA) && !abort_i;
   assign sm_blk_cnt_o = blk_q;
   assign busy_o       = !(state_q == ST_IDLE || state_q == ST_DONE);
   assign done_o       = state_q == ST_DONE;
   assign pass_o       = done_o && err_q == '0 && !tout_q;
   assign timeout_o    = tout_q;
   assign err_cnt_o    = err_q;
   assign first_err_o  = first_err_q;

endmodule

// File: tb/tb_emmc_traffic_gen.sv
// tb_emmc_traffic_gen: directed write/read-back runs against an emmc_sm responder model
// with a write-word scoreboard and a responder-side error expectation.
module tb_emmc_traffic_gen;

   localparam int WPB = 256;
   localparam int BIG = 1 << 30;

   logic        clk_core = 1'b0, rst_manual = 1'b1, run_i = 1'b0, abort_i = 1'b0;
   logic        sm_ready_i = 1'b0, sm_dvalid_i = 1'b0;
   logic [1:0]  mode_i = 2'd0;
   logic [15:0] blk_cnt_i = '0, sm_dat_i = '0;
   logic        sm_we_o, sm_start_o, busy_o, done_o, pass_o, timeout_o;
   logic [15:0] sm_blk_cnt_o, sm_dat_o;
   logic [3:0]  err_cnt_o;
   logic [23:0] first_err_o;

   int          checks = 0, errors = 0;
   int          starts, cyc, cyc_last, exp_err, exp_first;
   logic [15:0] exp_q[$], mem[$];

   emmc_traffic_gen #(
      .DATA_W(16), .BLK_BYTES(512), .BLK_W(16), .SEED(64'h5555),
      .GUARD_CYC(8), .TIMEOUT_CYC(64), .ERR_W(4)
   ) dut (
      .clk_core(clk_core), .rst_manual(rst_manual), .run_i(run_i), .abort_i(abort_i),
      .mode_i(mode_i), .blk_cnt_i(blk_cnt_i), .sm_we_o(sm_we_o), .sm_start_o(sm_start_o),
      .sm_blk_cnt_o(sm_blk_cnt_o), .sm_dat_o(sm_dat_o), .sm_ready_i(sm_ready_i),
      .sm_dat_i(sm_dat_i), .sm_dvalid_i(sm_dvalid_i), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .first_err_o(first_err_o)
   );

   always #5 clk_core = ~clk_core;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // x^16 + x^14 + x^13 + x^11 + 1 shifting towards the MSB.
   function automatic logic [15:0] nxt(input logic [1:0] m, input logic [15:0] w);
      return m == 2'd0 ? ~w : m == 2'd1 ? w + 16'd1 :
             m == 2'd2 ? {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]} : w;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dat"}, sm_dat_o, 16'h5555);
      check({tag, "_we"}, sm_we_o, 0);
      check({tag, "_start"}, sm_start_o, 0);
      check({tag, "_blk"}, sm_blk_cnt_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_pass"}, pass_o, 0);
      check({tag, "_tout"}, timeout_o, 0);
      check({tag, "_err"}, err_cnt_o, 0);
      check({tag, "_first"}, first_err_o, 0);
   endtask

   task automatic run_pass(input logic [1:0] mode, input logic [15:0] blk, input int flip_idx,
                           input bit inv_all, input int stall_after, input int abort_at,
                           input int reset_at);
      int          total, wr_n, rd_n;
      bit          rd_on, bad;
      logic [15:0] w, d;
      total = int'(blk) * WPB;
      wr_n = 0; rd_n = 0; rd_on = 0;
      starts = 0; cyc = 0; cyc_last = 0; exp_err = 0; exp_first = 0;
      exp_q.delete();
      mem.delete();
      w = 16'h5555;
      for (int i = 0; i < total; i++) begin
         exp_q.push_back(w);
         w = nxt(mode, w);
      end
      @(negedge clk_core);
      mode_i = mode; blk_cnt_i = blk; run_i = 1'b1;
      while (1) begin
         @(negedge clk_core);
         run_i = 1'b0;
         cyc++;
         if (done_o) break;
         if (cyc > 6000) begin
            check("run_budget_done", done_o, 1);
            break;
         end
         if (sm_start_o) starts++;
         sm_ready_i = 1'b0;
         sm_dvalid_i = 1'b0;
         if (sm_we_o && !sm_start_o && $urandom_range(0, 3) != 0) begin
            sm_ready_i = 1'b1;
            w = 'x;
            if (exp_q.size() != 0) w = exp_q.pop_front();
            check("wr_word", sm_dat_o, w);
            mem.push_back(sm_dat_o);
            wr_n++;
            if (wr_n == abort_at) begin
               abort_i = 1'b1;
               #1;
               check("abort_we_now", sm_we_o, 0);
               check("abort_start_now", sm_start_o, 0);
               @(negedge clk_core);
               abort_i = 1'b0;
               sm_ready_i = 1'b0;
               check("abort_busy", busy_o, 0);
               check("abort_done", done_o, 0);
               check("abort_we_next", sm_we_o, 0);
               return;
            end
         end
         if (rd_on && rd_n == reset_at) begin
            check("pre_reset_err", err_cnt_o, exp_err);
            rst_manual = 1'b1;
            #1;
            check_reset_outputs("rst_rd");
            @(negedge clk_core);
            rst_manual = 1'b0;
            return;
         end
         if (rd_on && rd_n < total && rd_n < stall_after && $urandom_range(0, 3) != 0) begin
            d = mem[rd_n];
            bad = inv_all || rd_n == flip_idx;
            if (inv_all) d = ~d;
            else if (rd_n == flip_idx) d[0] = ~d[0];
            if (bad) begin
               if (exp_err == 0) exp_first = rd_n;
               if (exp_err < 15) exp_err++;
            end
            sm_dat_i = d;
            sm_dvalid_i = 1'b1;
            rd_n++;
            cyc_last = cyc;
         end
         if (sm_start_o && !sm_we_o) rd_on = 1;
      end
      sm_ready_i = 1'b0;
      sm_dvalid_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk_core);
      check_reset_outputs("por");
      rst_manual = 1'b0;
      @(negedge clk_core);
      check_reset_outputs("idle");

      // ALT, two blocks, clean echo
      run_pass(2'd0, 16'd2, -1, 0, BIG, -1, -1);
      check("alt_done", done_o, 1);
      check("alt_pass", pass_o, 1);
      check("alt_err", err_cnt_o, 0);
      check("alt_tout", timeout_o, 0);
      check("alt_starts", starts, 2);
      check("alt_nwords", mem.size(), 512);
      check("alt_w0", mem[0], 16'h5555);
      check("alt_w1", mem[1], 16'hAAAA);
      check("alt_w2", mem[2], 16'h5555);
      check("alt_blk", sm_blk_cnt_o, 2);
      check("alt_busy", busy_o, 0);

      // INCR, one block, word 37 corrupted
      run_pass(2'd1, 16'd1, 37, 0, BIG, -1, -1);
      check("incr_done", done_o, 1);
      check("incr_err", err_cnt_o, 1);
      check("incr_first", first_err_o, 37);
      check("incr_pass", pass_o, 0);
      check("incr_w37", mem[37], 16'h557A);
      check("incr_w255", mem[255], 16'h5654);

      // zero blocks: straight to DONE with pass
      @(negedge clk_core);
      blk_cnt_i = 16'd0; run_i = 1'b1;
      @(negedge clk_core);
      run_i = 1'b0;
      check("zero_start", sm_start_o, 0);
      check("zero_done", done_o, 1);
      check("zero_pass", pass_o, 1);
      check("zero_err", err_cnt_o, 0);
      check("zero_first", first_err_o, 0);
      check("zero_busy", busy_o, 0);
      @(negedge clk_core);
      check("zero_start2", sm_start_o, 0);
      check("zero_done2", done_o, 1);

      // LFSR, responder stalls after 10 reads
      run_pass(2'd2, 16'd1, -1, 0, 10, -1, -1);
      check("lfsr_done", done_o, 1);
      check("lfsr_tout", timeout_o, 1);
      check("lfsr_pass", pass_o, 0);
      check("lfsr_err", err_cnt_o, 0);
      check("lfsr_stall_cycles", cyc - cyc_last - 1, 64);
      check("lfsr_w1", mem[1], 16'hAAAA);
      check("lfsr_w2", mem[2], 16'h5554);

      // abort in WR_DATA, then a fresh run from SEED
      run_pass(2'd1, 16'd1, -1, 0, BIG, 20, -1);
      check("abort_tout_cleared", timeout_o, 0);
      run_pass(2'd1, 16'd1, -1, 0, BIG, -1, -1);
      check("restart_starts", starts, 2);
      check("restart_seed", mem[0], 16'h5555);
      check("restart_pass", pass_o, 1);
      check("restart_done", done_o, 1);

      // reset during RD_DATA with an error already counted
      run_pass(2'd0, 16'd1, 2, 0, BIG, -1, 5);
      @(negedge clk_core);
      check_reset_outputs("post_rst");

      // CONST with every read word wrong: error counter saturates
      run_pass(2'd3, 16'd1, -1, 1, BIG, -1, -1);
      check("const_done", done_o, 1);
      check("const_err_sat", err_cnt_o, 15);
      check("const_err_model", err_cnt_o, exp_err);
      check("const_first", first_err_o, 0);
      check("const_pass", pass_o, 0);
      check("const_w255", mem[255], 16'h5555);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
